// File: rtl/activation_result_writer_pkg.sv
// Shared geometry of the activation/matmul datapath and the lane-masking helper
// used when committing activation rows to the result BRAM.
package activation_result_writer_pkg;

    localparam int DWIDTH       = 8;
    localparam int MAT_MUL_SIZE = 4;
    localparam int MASK_WIDTH   = MAT_MUL_SIZE;
    localparam int AWIDTH       = 10;
    localparam int ROW_WIDTH    = MAT_MUL_SIZE * DWIDTH;

    // Lanes whose validity bit is clear are forced to zero so the BRAM never sees stale bytes.
    function automatic logic [ROW_WIDTH-1:0] mask_lanes(
        input logic [ROW_WIDTH-1:0]  row,
        input logic [MASK_WIDTH-1:0] mask
    );
        logic [ROW_WIDTH-1:0] res;
        res = {ROW_WIDTH{1'b0}};
        for (int i = 0; i < MAT_MUL_SIZE; i++) begin
            if (mask[i]) begin
                res[i*DWIDTH +: DWIDTH] = row[i*DWIDTH +: DWIDTH];
            end else begin
                res[i*DWIDTH +: DWIDTH] = {DWIDTH{1'b0}};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/activation_result_writer_addr_gen.sv
// Strided address generator for the result writer: loads base/stride/row total on
// job start, advances once per accepted row and flags the final row of the job.
module activation_result_writer_addr_gen
    import activation_result_writer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH-1:0] addr_stride,
    input  logic [AWIDTH-1:0] num_rows,
    input  logic              advance,
    output logic [AWIDTH-1:0] cur_addr,
    output logic              last_row
);

    localparam logic [AWIDTH-1:0] ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

    logic [AWIDTH-1:0] cur_addr_d, cur_addr_q;
    logic [AWIDTH-1:0] stride_d,   stride_q;
    logic [AWIDTH-1:0] total_d,    total_q;
    logic [AWIDTH-1:0] row_cnt_d,  row_cnt_q;

    // Next-state for address, stride, row total and row counter; addition wraps silently.
    always_comb begin
        cur_addr_d = cur_addr_q;
        stride_d   = stride_q;
        total_d    = total_q;
        row_cnt_d  = row_cnt_q;
        if (load) begin
            cur_addr_d = base_addr;
            stride_d   = addr_stride;
            total_d    = num_rows;
            row_cnt_d  = {AWIDTH{1'b0}};
        end else if (advance) begin
            cur_addr_d = cur_addr_q + stride_q;
            row_cnt_d  = row_cnt_q + ONE;
        end else begin
            cur_addr_d = cur_addr_q;
            row_cnt_d  = row_cnt_q;
        end
    end

    // Address generator state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_addr_q <= {AWIDTH{1'b0}};
            stride_q   <= {AWIDTH{1'b0}};
            total_q    <= {AWIDTH{1'b0}};
            row_cnt_q  <= {AWIDTH{1'b0}};
        end else begin
            cur_addr_q <= cur_addr_d;
            stride_q   <= stride_d;
            total_q    <= total_d;
            row_cnt_q  <= row_cnt_d;
        end
    end

    assign cur_addr = cur_addr_q;
    assign last_row = ((row_cnt_q + ONE) == total_q);

endmodule

// File: rtl/activation_result_writer.sv
// Commits activation-stage row vectors to the result BRAM at strided addresses
// with per-lane byte enables, and reports job completion to the controller.
module activation_result_writer
    import activation_result_writer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [AWIDTH-1:0]     base_addr,
    input  logic [AWIDTH-1:0]     addr_stride,
    input  logic [AWIDTH-1:0]     num_rows,
    input  logic [MASK_WIDTH-1:0] validity_mask,
    input  logic                  in_data_available,
    input  logic [ROW_WIDTH-1:0]  inp_data,
    output logic [AWIDTH-1:0]     bram_addr,
    output logic [ROW_WIDTH-1:0]  bram_wdata,
    output logic [MASK_WIDTH-1:0] bram_we,
    output logic                  busy,
    output logic                  done,
    output logic                  drop_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                state_d, state_q;
    logic [MASK_WIDTH-1:0] mask_d, mask_q;
    logic [AWIDTH-1:0]     bram_addr_d, bram_addr_q;
    logic [ROW_WIDTH-1:0]  bram_wdata_d, bram_wdata_q;
    logic [MASK_WIDTH-1:0] bram_we_d, bram_we_q;
    logic                  busy_d, busy_q;
    logic                  done_d, done_q;
    logic                  drop_err_d, drop_err_q;

    logic                  start_ok_s;
    logic                  accept_s;
    logic [AWIDTH-1:0]     cur_addr_s;
    logic                  last_row_s;

    // Start is honoured only from IDLE; rows are taken only in RUN.
    assign start_ok_s = start && (state_q == ST_IDLE);
    assign accept_s   = in_data_available && (state_q == ST_RUN);

    activation_result_writer_addr_gen u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .load        (start_ok_s),
        .base_addr   (base_addr),
        .addr_stride (addr_stride),
        .num_rows    (num_rows),
        .advance     (accept_s),
        .cur_addr    (cur_addr_s),
        .last_row    (last_row_s)
    );

    // FSM next state plus the registered BRAM write port and status outputs.
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        bram_addr_d  = bram_addr_q;
        bram_wdata_d = bram_wdata_q;
        bram_we_d    = {MASK_WIDTH{1'b0}};
        drop_err_d   = drop_err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d  = validity_mask;
                    state_d = (num_rows == {AWIDTH{1'b0}}) ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s && last_row_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept_s) begin
            bram_addr_d  = cur_addr_s;
            bram_wdata_d = mask_lanes(inp_data, mask_q);
            bram_we_d    = mask_q;
        end else begin
            bram_we_d    = {MASK_WIDTH{1'b0}};
        end

        // A stray row in the same cycle as start still counts as a drop.
        if (in_data_available && (state_q != ST_RUN)) begin
            drop_err_d = 1'b1;
        end else if (start_ok_s) begin
            drop_err_d = 1'b0;
        end else begin
            drop_err_d = drop_err_q;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mask_q       <= {MASK_WIDTH{1'b0}};
            bram_addr_q  <= {AWIDTH{1'b0}};
            bram_wdata_q <= {ROW_WIDTH{1'b0}};
            bram_we_q    <= {MASK_WIDTH{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            drop_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            bram_addr_q  <= bram_addr_d;
            bram_wdata_q <= bram_wdata_d;
            bram_we_q    <= bram_we_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            drop_err_q   <= drop_err_d;
        end
    end

    assign bram_addr  = bram_addr_q;
    assign bram_wdata = bram_wdata_q;
    assign bram_we    = bram_we_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign drop_err   = drop_err_q;

endmodule
